pc_stack_sequencer: RTL and testbench
=====================================

Name: pc_stack_sequencer

Overview:
Parametrised program-counter sequencer for the synchronous-execution processor. It succeeds the plain 6-bit PC register and adds four things: relative branch, call/return with an internal return-address stack, stall gating, and sticky stack-error flags. It sits between the control FSM and instruction memory, and PC drives the instruction-memory address directly.

Parameters:
WIDTH, 6, PC and address width in bits (minimum 2).
DEPTH, 4, number of return-address stack entries (minimum 1).
SPW, 3, stack-count width; must satisfy 2^SPW > DEPTH.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
PCen  input  1  increment enable (PC <= PC+1).
wren  input  1  absolute load (PC <= data).
bren  input  1  relative branch (PC <= PC + sign-extended offset).
call  input  1  subroutine call: push PC+1, then PC <= data.
ret  input  1  subroutine return: PC <= top of stack, then pop.
clr_err  input  1  synchronous clear of the sticky error flags.
data  input  WIDTH  absolute target for wren and call.
offset  input  WIDTH  two's-complement branch displacement.
PC  output  WIDTH  current program counter (registered).
sp  output  SPW  number of valid stack entries, 0..DEPTH.
stack_full  output  1  sp == DEPTH (combinational from sp).
stack_empty  output  1  sp == 0 (combinational from sp).
ovf_err  output  1  sticky flag: call attempted while full.
udf_err  output  1  sticky flag: ret attempted while empty.

Behaviour:
- Reset: resetn low clears PC, sp, ovf_err and udf_err to 0 immediately, without waiting for a clock edge. Stack contents are don't-care. Reset asserted mid-operation aborts any pending update. The first edge after resetn rises is evaluated normally.
- Command priority is evaluated each rising edge, highest first: wren > ret > call > bren > PCen. Only the highest-priority asserted command takes effect; lower ones are ignored that cycle.
- No command asserted: PC holds (stall).
- wren: PC <= data. Stack untouched.
- ret with sp > 0: PC <= stack[sp-1]; sp <= sp-1.
- ret with sp == 0: PC holds; sp stays 0; udf_err <= 1.
- call with sp < DEPTH: stack[sp] <= PC+1 (mod 2^WIDTH); sp <= sp+1; PC <= data.
- call with sp == DEPTH: the whole command is ignored (no push, PC holds); ovf_err <= 1.
- bren: PC <= PC + offset, computed modulo 2^WIDTH. Negative offsets branch backward. Offset 0 holds PC.
- PCen: PC <= PC+1. Wraps from 2^WIDTH-1 to 0 with no flag.
- PC+1 pushed by call also wraps; a call at PC = 2^WIDTH-1 pushes 0.
- clr_err clears both flags at the edge. If an error occurs in the same cycle as clr_err, the new error wins and the flag ends at 1.
- Latency: every update is visible on PC and sp one cycle after the command edge. The flags are combinational from registered sp.
- Stack is LIFO. A ret returns the most recent unpopped call address, so nesting to DEPTH levels is exact.

Test Plan:
- Reset and increment: resetn pulsed low between edges -> PC=0 and sp=0 immediately. PCen held for 64 cycles (WIDTH=6) -> PC counts 0..63 then wraps to 0.
- Priority: at PC=5, assert wren (data=20), ret, call and PCen together with sp=1 (top=9) -> PC=20, sp=1. Next cycle ret only -> PC=9, sp=0.
- Nested calls, DEPTH=4: at PC=10, issue call data=30, 40, 50, 60 on consecutive cycles -> stack holds 11, 31, 41, 51, sp=4, stack_full=1. Four rets -> PC=51, 41, 31, 11, ending with sp=0 and stack_empty=1.
- Overflow and underflow: a fifth call while full -> PC unchanged, sp=4, ovf_err=1. Drain the stack, then ret -> PC unchanged, udf_err=1. clr_err -> both flags 0. clr_err together with a new underflow -> udf_err stays 1.
- Relative branch: at PC=3, bren with offset=6'b111110 (-2) -> PC=1. At PC=62, offset=5 -> PC=3 (wrap).
- Asynchronous reset mid-call: at sp=2, assert call and drop resetn before the edge -> PC=0, sp=0, no push. After release, ret -> udf_err=1.

Source files
------------

// File: rtl/pc_stack_sequencer.sv
// ---------------------------------------------------------------------------
// pc_stack_sequencer
//   Program-counter sequencer. Each rising edge applies one command, and PC
//   drives the instruction-memory address. The supported commands are
//   absolute load, return, call, relative branch and increment. A small
//   internal LIFO holds return addresses. Sticky flags record a call made
//   while the stack is full and a return made while it is empty.
//
// Parameters
//   WIDTH  PC / address width (>= 2)
//   DEPTH  return-address stack entries (>= 1)
//   SPW    stack-count width, 2**SPW > DEPTH
//
// Ports
//   Clock        in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   PCen         in   PC <= PC+1
//   wren         in   PC <= data
//   bren         in   PC <= PC + offset (two's complement)
//   call         in   push PC+1, PC <= data
//   ret          in   PC <= top of stack, pop
//   clr_err      in   synchronous clear of ovf_err / udf_err
//   data         in   absolute target for wren and call
//   offset       in   branch displacement
//   PC           out  registered program counter
//   sp           out  number of valid stack entries
//   stack_full   out  sp == DEPTH
//   stack_empty  out  sp == 0
//   ovf_err      out  sticky: call while full
//   udf_err      out  sticky: ret while empty
//
// Command priority, highest first: wren > ret > call > bren > PCen.
// With no command asserted, PC holds (stall).
// ---------------------------------------------------------------------------
module pc_stack_sequencer #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4,
   parameter int SPW   = 3
) (
   input  logic             Clock,
   input  logic             resetn,
   input  logic             PCen,
   input  logic             wren,
   input  logic             bren,
   input  logic             call,
   input  logic             ret,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] offset,
   output logic [WIDTH-1:0] PC,
   output logic [SPW-1:0]   sp,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             ovf_err,
   output logic             udf_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);
   localparam logic [SPW-1:0]   SP_ONE  = SPW'(1);
   localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);

   logic [WIDTH-1:0] stack_mem [DEPTH];

   logic [WIDTH-1:0] pc_plus1;
   logic [WIDTH-1:0] pc_nxt;
   logic [SPW-1:0]   sp_nxt;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    pop_idx;
   logic             push;
   logic             ovf_set;
   logic             udf_set;

   assign stack_full  = (sp == SP_FULL);
   assign stack_empty = (sp == '0);

   // Both additions wrap modulo 2**WIDTH by truncation. A call at the top
   // address therefore pushes 0.
   assign pc_plus1 = PC + PC_ONE;
   assign push_idx = AW'(sp);
   assign pop_idx  = AW'(sp - SP_ONE);

   always_comb begin
      pc_nxt  = PC;
      sp_nxt  = sp;
      push    = 1'b0;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (wren) begin
         pc_nxt = data;
      end else if (ret) begin
         if (stack_empty) begin
            udf_set = 1'b1;
         end else begin
            pc_nxt = stack_mem[pop_idx];
            sp_nxt = sp - SP_ONE;
         end
      end else if (call) begin
         // A call while full is dropped entirely: no push and no jump.
         if (stack_full) begin
            ovf_set = 1'b1;
         end else begin
            push   = 1'b1;
            pc_nxt = data;
            sp_nxt = sp + SP_ONE;
         end
      end else if (bren) begin
         pc_nxt = PC + offset;
      end else if (PCen) begin
         pc_nxt = pc_plus1;
      end
   end

   always_ff @(posedge Clock or negedge resetn) begin
      if (!resetn) begin
         PC      <= '0;
         sp      <= '0;
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         PC      <= pc_nxt;
         sp      <= sp_nxt;
         // A new error in the same cycle as clr_err leaves the flag set.
         ovf_err <= ovf_set | (ovf_err & ~clr_err);
         udf_err <= udf_set | (udf_err & ~clr_err);
      end
   end

   // Stack storage is not reset because its contents are meaningless while
   // sp is 0. Pushes are still gated by resetn, so a call that overlaps reset
   // leaves nothing behind.
   always_ff @(posedge Clock) begin
      if (push && resetn) begin
         stack_mem[push_idx] <= pc_plus1;
      end
   end

endmodule

// File: tb/tb_pc_stack_sequencer.sv
module tb_pc_stack_sequencer;

   localparam int W = 6;
   localparam int D = 4;
   localparam int S = 3;

   // clock / reset
   logic Clock = 1'b0;
   logic resetn = 1'b0;
   always #5 Clock = ~Clock;

   logic PCen, wren, bren, call, ret, clr_err;
   logic [W-1:0] data, offset;
   logic [W-1:0] PC;
   logic [S-1:0] sp;
   logic stack_full, stack_empty, ovf_err, udf_err;

   pc_stack_sequencer #(.WIDTH(W), .DEPTH(D), .SPW(S)) dut (
      .Clock(Clock), .resetn(resetn), .PCen(PCen), .wren(wren), .bren(bren),
      .call(call), .ret(ret), .clr_err(clr_err), .data(data), .offset(offset),
      .PC(PC), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
      .ovf_err(ovf_err), .udf_err(udf_err)
   );

   typedef struct {
      string        name;
      logic         wren, ret, call, bren, pcen, clr;
      logic [W-1:0] data, offset;
      logic [W-1:0] e_pc;
      logic [S-1:0] e_sp;
      logic         e_ovf, e_udf;
   } vec_t;

   vec_t vecs[$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic vec_t mk(string name, logic w, logic r, logic c, logic b,
                               logic p, logic cl, int d, int off, int epc,
                               int esp, logic eo, logic eu);
      vec_t v;
      v.name = name; v.wren = w; v.ret = r; v.call = c; v.bren = b;
      v.pcen = p; v.clr = cl; v.data = W'(d); v.offset = W'(off);
      v.e_pc = W'(epc); v.e_sp = S'(esp); v.e_ovf = eo; v.e_udf = eu;
      return v;
   endfunction

   // scoreboard
   task automatic cmp(string name, string field, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s.%s actual=%0d expected=%0d", name, field, act, exp);
      end
   endtask

   task automatic check(string name, int epc, int esp, logic eo, logic eu);
      cmp(name, "PC", int'(PC), epc);
      cmp(name, "sp", int'(sp), esp);
      cmp(name, "stack_full", int'(stack_full), int'(esp == D));
      cmp(name, "stack_empty", int'(stack_empty), int'(esp == 0));
      cmp(name, "ovf_err", int'(ovf_err), int'(eo));
      cmp(name, "udf_err", int'(udf_err), int'(eu));
   endtask

   // drivers
   task automatic idle_inputs();
      PCen = 0; wren = 0; bren = 0; call = 0; ret = 0; clr_err = 0;
      data = '0; offset = '0;
   endtask

   task automatic apply(vec_t v);
      @(negedge Clock);
      wren = v.wren; ret = v.ret; call = v.call; bren = v.bren;
      PCen = v.pcen; clr_err = v.clr; data = v.data; offset = v.offset;
      @(posedge Clock);
      #1;
      check(v.name, int'(v.e_pc), int'(v.e_sp), v.e_ovf, v.e_udf);
   endtask

   initial begin
      idle_inputs();

      // reset state while held
      #2;
      check("reset_hold", 0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      resetn = 1'b1;

      // increment over the full range and wrap
      for (int i = 1; i <= 67; i++) begin
         @(negedge Clock);
         PCen = 1'b1;
         @(posedge Clock);
         #1;
         if (i == 64) check("inc_wrap", 0, 0, 1'b0, 1'b0);
         else cmp("inc", "PC", int'(PC), i % 64);
      end
      idle_inputs();

      // asynchronous reset between edges
      @(negedge Clock);
      resetn = 1'b0;
      #1;
      check("async_reset", 0, 0, 1'b0, 1'b0);
      @(negedge Clock);
      resetn = 1'b1;

      //                 name          wr re ca br pc cl data off  pc sp ovf udf
      vecs.push_back(mk("ld8",         1, 0, 0, 0, 0, 0,  8,  0,  8, 0, 0, 0));
      vecs.push_back(mk("call5",       0, 0, 1, 0, 0, 0,  5,  0,  5, 1, 0, 0));
      vecs.push_back(mk("prio_all",    1, 1, 1, 0, 1, 0, 20,  0, 20, 1, 0, 0));
      vecs.push_back(mk("ret9",        0, 1, 0, 0, 0, 0,  0,  0,  9, 0, 0, 0));
      vecs.push_back(mk("ld10",        1, 0, 0, 0, 0, 0, 10,  0, 10, 0, 0, 0));
      vecs.push_back(mk("call30",      0, 0, 1, 0, 0, 0, 30,  0, 30, 1, 0, 0));
      vecs.push_back(mk("call40",      0, 0, 1, 0, 0, 0, 40,  0, 40, 2, 0, 0));
      vecs.push_back(mk("call50",      0, 0, 1, 0, 0, 0, 50,  0, 50, 3, 0, 0));
      vecs.push_back(mk("call60",      0, 0, 1, 0, 0, 0, 60,  0, 60, 4, 0, 0));
      vecs.push_back(mk("call_ovf",    0, 0, 1, 0, 0, 0,  7,  0, 60, 4, 1, 0));
      vecs.push_back(mk("ret51",       0, 1, 0, 0, 0, 0,  0,  0, 51, 3, 1, 0));
      vecs.push_back(mk("ret41",       0, 1, 0, 0, 0, 0,  0,  0, 41, 2, 1, 0));
      vecs.push_back(mk("ret31",       0, 1, 0, 0, 0, 0,  0,  0, 31, 1, 1, 0));
      vecs.push_back(mk("ret11",       0, 1, 0, 0, 0, 0,  0,  0, 11, 0, 1, 0));
      vecs.push_back(mk("ret_udf",     0, 1, 0, 0, 0, 0,  0,  0, 11, 0, 1, 1));
      vecs.push_back(mk("clr",         0, 0, 0, 0, 0, 1,  0,  0, 11, 0, 0, 0));
      vecs.push_back(mk("clr_ret",     0, 1, 0, 0, 0, 1,  0,  0, 11, 0, 0, 1));
      vecs.push_back(mk("clr2",        0, 0, 0, 0, 0, 1,  0,  0, 11, 0, 0, 0));
      vecs.push_back(mk("ld3",         1, 0, 0, 0, 0, 0,  3,  0,  3, 0, 0, 0));
      vecs.push_back(mk("br_m2",       0, 0, 0, 1, 0, 0,  0, 62,  1, 0, 0, 0));
      vecs.push_back(mk("ld62",        1, 0, 0, 0, 0, 0, 62,  0, 62, 0, 0, 0));
      vecs.push_back(mk("br_wrap",     0, 0, 0, 1, 0, 0,  0,  5,  3, 0, 0, 0));
      vecs.push_back(mk("br_zero",     0, 0, 0, 1, 0, 0,  0,  0,  3, 0, 0, 0));
      vecs.push_back(mk("br_vs_pcen",  0, 0, 0, 1, 1, 0,  0,  1,  4, 0, 0, 0));
      vecs.push_back(mk("stall",       0, 0, 0, 0, 0, 0, 33,  9,  4, 0, 0, 0));
      vecs.push_back(mk("ld63",        1, 0, 0, 0, 0, 0, 63,  0, 63, 0, 0, 0));
      vecs.push_back(mk("call_wrap",   0, 0, 1, 0, 0, 0,  2,  0,  2, 1, 0, 0));
      vecs.push_back(mk("ret_wrap0",   0, 1, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0));
      vecs.push_back(mk("call_vs_br",  0, 0, 1, 1, 0, 0, 12, 10, 12, 1, 0, 0));
      vecs.push_back(mk("ret_vs_call", 0, 1, 1, 0, 0, 0, 33,  0,  1, 0, 0, 0));
      vecs.push_back(mk("pcen",        0, 0, 0, 0, 1, 0,  0,  0,  2, 0, 0, 0));

      foreach (vecs[i]) apply(vecs[i]);

      // reset during a call: no push survives, flags cleared
      apply(mk("pre_udf",  0, 1, 0, 0, 0, 0,  0, 0,  2, 0, 0, 1));
      apply(mk("pre_c20",  0, 0, 1, 0, 0, 0, 20, 0, 20, 1, 0, 1));
      apply(mk("pre_c30",  0, 0, 1, 0, 0, 0, 30, 0, 30, 2, 0, 1));
      @(negedge Clock);
      idle_inputs();
      call = 1'b1;
      data = 6'd40;
      #2;
      resetn = 1'b0;
      #1;
      check("rst_mid_call", 0, 0, 1'b0, 1'b0);
      @(posedge Clock);
      #1;
      check("rst_mid_call_edge", 0, 0, 1'b0, 1'b0);
      @(negedge Clock);
      idle_inputs();
      resetn = 1'b1;
      apply(mk("post_rst_ret", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
